// File: rtl/wb_mailbox_pkg.sv
// Shared register map for the Wishbone mailbox: offsets, bit positions, register-select enum.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wb_mailbox_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_IRQEN  = 2'd3;

   typedef enum logic [1:0] {
      SEL_DATA   = REG_DATA,
      SEL_STATUS = REG_STATUS,
      SEL_CTRL   = REG_CTRL,
      SEL_IRQEN  = REG_IRQEN
   } reg_sel_e;

   localparam int STAT_RX_NEMPTY  = 0;
   localparam int STAT_TX_FULL    = 1;
   localparam int STAT_ERR        = 2;
   localparam int STAT_RX_CNT_LSB = 8;
   localparam int STAT_TX_CNT_LSB = 16;

   localparam int CTRL_FLUSH_TX = 0;
   localparam int CTRL_FLUSH_RX = 1;
   localparam int CTRL_CLR_ERR  = 2;

   localparam int IRQEN_RX_NEMPTY = 0;
   localparam int IRQEN_TX_NFULL  = 1;
   localparam int IRQEN_ERR       = 2;

endpackage

// File: rtl/mb_fifo.sv
// Synchronous FIFO with push, pop, flush and occupancy count; head word is combinational.
// Latency: a pushed word is visible at the head one cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; flush overrides both.
module mb_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   input  logic                       flush,
   output logic [WIDTH-1:0]           head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/wb_mailbox.sv
// Wishbone mailbox: CPU<->stream FIFOs with DATA/STATUS/CTRL/IRQEN registers; IRQ logic under WB_MAILBOX_IRQ_EN.
// Latency: every request is answered with a one-cycle ack or err in the next cycle.
// Backpressure: in_ready drops when RX is full; out_valid follows TX non-empty.
module wb_mailbox
   import wb_mailbox_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int WB_DATA = 32
) (
   input  logic                 wb_clk,
   input  logic                 wb_rst,
   input  logic [31:0]          wb_adr_i,
   input  logic [WB_DATA-1:0]   wb_dat_i,
   input  logic [WB_DATA/8-1:0] wb_sel_i,
   input  logic                 wb_we_i,
   input  logic                 wb_cyc_i,
   input  logic                 wb_stb_i,
   output logic [WB_DATA-1:0]   wb_dat_o,
   output logic                 wb_ack_o,
   output logic                 wb_err_o,
   input  logic                 in_valid,
   input  logic [WB_DATA-1:0]   in_data,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [WB_DATA-1:0]   out_data,
   input  logic                 out_ready,
   output logic                 irq
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic               req;
   reg_sel_e           sel;
   logic [WB_DATA-1:0] wdata_masked;
   logic [WB_DATA-1:0] rdata;
   logic [WB_DATA-1:0] status;
   logic [WB_DATA-1:0] irqen_rd;
   logic               err_flag;
   logic               err_set;
   logic               err_clr;
   logic               irqen_wr;

   logic               tx_push, tx_pop, tx_flush, tx_full, tx_empty;
   logic               rx_push, rx_pop, rx_flush, rx_full, rx_empty;
   logic [CW-1:0]      tx_count, rx_count;
   logic [WB_DATA-1:0] rx_head;

   wire unused_adr = &{1'b0, wb_adr_i[31:4], wb_adr_i[1:0]};

   // Outstanding ack/err masks the request so a held strobe is served only once.
   assign req = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
   assign sel = reg_sel_e'(wb_adr_i[3:2]);

   assign in_ready  = ~rx_full;
   assign rx_push   = in_valid & in_ready;
   assign out_valid = ~tx_empty;
   assign tx_pop    = out_valid & out_ready;

   mb_fifo #(.DEPTH(DEPTH), .WIDTH(WB_DATA)) u_tx_fifo (
      .clk       (wb_clk),
      .rst       (wb_rst),
      .push      (tx_push),
      .push_data (wdata_masked),
      .pop       (tx_pop),
      .flush     (tx_flush),
      .head      (out_data),
      .full      (tx_full),
      .empty     (tx_empty),
      .count     (tx_count)
   );

   mb_fifo #(.DEPTH(DEPTH), .WIDTH(WB_DATA)) u_rx_fifo (
      .clk       (wb_clk),
      .rst       (wb_rst),
      .push      (rx_push),
      .push_data (in_data),
      .pop       (rx_pop),
      .flush     (rx_flush),
      .head      (rx_head),
      .full      (rx_full),
      .empty     (rx_empty),
      .count     (rx_count)
   );

   always_comb begin
      status                                 = '0;
      status[STAT_RX_NEMPTY]                 = ~rx_empty;
      status[STAT_TX_FULL]                   = tx_full;
      status[STAT_ERR]                       = err_flag;
      status[STAT_RX_CNT_LSB +: 8]           = 8'(rx_count);
      status[STAT_TX_CNT_LSB +: 8]           = 8'(tx_count);
   end

   always_comb begin
      wdata_masked = '0;
      for (int b = 0; b < WB_DATA/8; b++) begin
         wdata_masked[b*8 +: 8] = wb_sel_i[b] ? wb_dat_i[b*8 +: 8] : 8'h00;
      end
   end

   always_comb begin
      tx_push  = 1'b0;
      rx_pop   = 1'b0;
      tx_flush = 1'b0;
      rx_flush = 1'b0;
      err_set  = 1'b0;
      err_clr  = 1'b0;
      irqen_wr = 1'b0;
      rdata    = '0;
      if (req) begin
         case (sel)
            SEL_DATA: begin
               if (wb_we_i) begin
                  if (tx_full) err_set = 1'b1;
                  else         tx_push = 1'b1;
               end else begin
                  if (rx_empty) begin
                     err_set = 1'b1;
                  end else begin
                     rx_pop = 1'b1;
                     rdata  = rx_head;
                  end
               end
            end
            SEL_STATUS: begin
               if (!wb_we_i) rdata = status;
            end
            SEL_CTRL: begin
               if (wb_we_i) begin
                  tx_flush = wb_dat_i[CTRL_FLUSH_TX];
                  rx_flush = wb_dat_i[CTRL_FLUSH_RX];
                  err_clr  = wb_dat_i[CTRL_CLR_ERR];
               end
            end
            default: begin
               if (wb_we_i) irqen_wr = 1'b1;
               else         rdata    = irqen_rd;
            end
         endcase
      end
   end

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         wb_ack_o <= 1'b0;
         wb_err_o <= 1'b0;
         wb_dat_o <= '0;
         err_flag <= 1'b0;
      end else begin
         wb_ack_o <= req & ~err_set;
         wb_err_o <= req & err_set;
         if (req) begin
            wb_dat_o <= rdata;
         end
         if (err_set)      err_flag <= 1'b1;
         else if (err_clr) err_flag <= 1'b0;
      end
   end

`ifdef WB_MAILBOX_IRQ_EN
   logic [2:0] irqen;
   logic [2:0] irq_src;

   always_comb begin
      irq_src                  = '0;
      irq_src[IRQEN_RX_NEMPTY] = ~rx_empty;
      irq_src[IRQEN_TX_NFULL]  = ~tx_full;
      irq_src[IRQEN_ERR]       = err_flag;
   end

   assign irqen_rd = WB_DATA'(irqen);

   always_ff @(posedge wb_clk) begin
      if (wb_rst) begin
         irqen <= '0;
         irq   <= 1'b0;
      end else begin
         if (irqen_wr) begin
            irqen <= wb_dat_i[2:0];
         end
         irq <= |(irqen & irq_src);
      end
   end
`else
   wire unused_irqen_wr = irqen_wr;

   assign irqen_rd = '0;
   assign irq      = 1'b0;
`endif

endmodule
